// File: rtl/issue_scoreboard_if.sv
// Operands-stage <-> scoreboard bundle: per-slot operand/destination info,
// writeback completions, and the stall/sid/occupancy responses.
interface issue_scoreboard_if #(
  parameter int unsigned SB_IDX_W = 3
);
  logic              flush_i;

  logic              inst0_valid_i;
  logic              inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i;
  logic [4:0]        inst0_rs1_i, inst0_rs2_i, inst0_rs3_i;
  logic [1:0]        inst0_rd_type_i;
  logic [4:0]        inst0_rd_i;

  logic              inst1_valid_i;
  logic              inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i;
  logic [4:0]        inst1_rs1_i, inst1_rs2_i, inst1_rs3_i;
  logic [1:0]        inst1_rd_type_i;
  logic [4:0]        inst1_rd_i;

  logic              inst0_wb_valid_i, inst1_wb_valid_i;
  logic [SB_IDX_W:0] inst0_wb_sid_i, inst1_wb_sid_i;

  logic              stall_inst0_o, stall_inst1_o;
  logic [SB_IDX_W:0] inst0_sid_o, inst1_sid_o;
  logic [SB_IDX_W:0] count_o;
  logic              empty_o;

  modport master (
    output flush_i,
    output inst0_valid_i, inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i,
    output inst0_rs1_i, inst0_rs2_i, inst0_rs3_i, inst0_rd_type_i, inst0_rd_i,
    output inst1_valid_i, inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i,
    output inst1_rs1_i, inst1_rs2_i, inst1_rs3_i, inst1_rd_type_i, inst1_rd_i,
    output inst0_wb_valid_i, inst1_wb_valid_i, inst0_wb_sid_i, inst1_wb_sid_i,
    input  stall_inst0_o, stall_inst1_o, inst0_sid_o, inst1_sid_o, count_o, empty_o
  );

  modport slave (
    input  flush_i,
    input  inst0_valid_i, inst0_rs1_valid_i, inst0_rs2_valid_i, inst0_rs3_valid_i,
    input  inst0_rs1_i, inst0_rs2_i, inst0_rs3_i, inst0_rd_type_i, inst0_rd_i,
    input  inst1_valid_i, inst1_rs1_valid_i, inst1_rs2_valid_i, inst1_rs3_valid_i,
    input  inst1_rs1_i, inst1_rs2_i, inst1_rs3_i, inst1_rd_type_i, inst1_rd_i,
    input  inst0_wb_valid_i, inst1_wb_valid_i, inst0_wb_sid_i, inst1_wb_sid_i,
    output stall_inst0_o, stall_inst1_o, inst0_sid_o, inst1_sid_o, count_o, empty_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue in-order scoreboard: circular table of in-flight destinations,
// RAW/WAW/overflow stall generation, writeback completion, in-order retire.
module issue_scoreboard #(
  parameter int unsigned SB_DEPTH = 8,
  parameter int unsigned SB_IDX_W = 3
) (
  input logic               clk,
  input logic               rst,
  issue_scoreboard_if.slave sb
);
  typedef logic [SB_IDX_W:0]   sid_t;
  typedef logic [SB_IDX_W-1:0] idx_t;

  sid_t                head_q, tail_q, count, free, sid1, wb0_off, wb1_off;
  logic [SB_DEPTH-1:0] busy_q, done_q;
  logic [1:0]          rd_type_q [SB_DEPTH];
  logic [4:0]          rd_q      [SB_DEPTH];
  logic [31:0]         pending;
  logic                real_rd0, real_rd1, haz0, haz1, intra;
  logic                stall0, stall1, disp0, disp1;
  logic                wb0_hit, wb1_hit, ret0, ret1;
  idx_t                s0_idx, s1_idx, h0_idx, h1_idx, wb0_idx, wb1_idx;

  function automatic logic is_real_rd(input logic [1:0] t, input logic [4:0] r);
    return (t == 2'b10) || ((t == 2'b01) && (r != 5'd0));
  endfunction

  // Collapse the table into a per-register "write outstanding" mask; sources
  // then match by index alone, regardless of int/fp type.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++)
      if (busy_q[i] && !done_q[i] && is_real_rd(rd_type_q[i], rd_q[i]))
        pending[rd_q[i]] = 1'b1;
  end

  assign count = tail_q - head_q;
  assign free  = sid_t'(SB_DEPTH) - count;

  always_comb begin
    real_rd0 = is_real_rd(sb.inst0_rd_type_i, sb.inst0_rd_i);
    real_rd1 = is_real_rd(sb.inst1_rd_type_i, sb.inst1_rd_i);
    haz0 = (sb.inst0_rs1_valid_i && pending[sb.inst0_rs1_i]) ||
           (sb.inst0_rs2_valid_i && pending[sb.inst0_rs2_i]) ||
           (sb.inst0_rs3_valid_i && pending[sb.inst0_rs3_i]) ||
           (real_rd0 && pending[sb.inst0_rd_i]);
    haz1 = (sb.inst1_rs1_valid_i && pending[sb.inst1_rs1_i]) ||
           (sb.inst1_rs2_valid_i && pending[sb.inst1_rs2_i]) ||
           (sb.inst1_rs3_valid_i && pending[sb.inst1_rs3_i]) ||
           (real_rd1 && pending[sb.inst1_rd_i]);
    // An invalid inst0 carries no destination, so it cannot shadow inst1.
    intra = sb.inst0_valid_i && real_rd0 &&
            ((sb.inst1_rs1_valid_i && (sb.inst1_rs1_i == sb.inst0_rd_i)) ||
             (sb.inst1_rs2_valid_i && (sb.inst1_rs2_i == sb.inst0_rd_i)) ||
             (sb.inst1_rs3_valid_i && (sb.inst1_rs3_i == sb.inst0_rd_i)) ||
             (real_rd1 && (sb.inst1_rd_i == sb.inst0_rd_i)));
    stall0 = sb.inst0_valid_i && (haz0 || (free == '0));
    disp0  = sb.inst0_valid_i && !stall0 && !sb.flush_i;
    stall1 = sb.inst1_valid_i &&
             (stall0 || haz1 || intra || (free == '0) || (disp0 && (free == sid_t'(1))));
    disp1  = sb.inst1_valid_i && !stall1 && !sb.flush_i;
  end

  assign sid1    = tail_q + sid_t'(disp0);
  assign s0_idx  = tail_q[SB_IDX_W-1:0];
  assign s1_idx  = sid1[SB_IDX_W-1:0];
  assign h0_idx  = head_q[SB_IDX_W-1:0];
  assign h1_idx  = h0_idx + idx_t'(1);
  assign wb0_idx = sb.inst0_wb_sid_i[SB_IDX_W-1:0];
  assign wb1_idx = sb.inst1_wb_sid_i[SB_IDX_W-1:0];
  assign wb0_off = sb.inst0_wb_sid_i - head_q;
  assign wb1_off = sb.inst1_wb_sid_i - head_q;
  assign wb0_hit = sb.inst0_wb_valid_i && busy_q[wb0_idx] && (wb0_off < count);
  assign wb1_hit = sb.inst1_wb_valid_i && busy_q[wb1_idx] && (wb1_off < count);
  assign ret0    = busy_q[h0_idx] && done_q[h0_idx];
  assign ret1    = ret0 && busy_q[h1_idx] && done_q[h1_idx];

  always_ff @(posedge clk) begin
    if (rst || sb.flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      if (disp0) begin
        busy_q[s0_idx]    <= 1'b1;
        done_q[s0_idx]    <= 1'b0;
        rd_type_q[s0_idx] <= sb.inst0_rd_type_i;
        rd_q[s0_idx]      <= sb.inst0_rd_i;
      end
      if (disp1) begin
        busy_q[s1_idx]    <= 1'b1;
        done_q[s1_idx]    <= 1'b0;
        rd_type_q[s1_idx] <= sb.inst1_rd_type_i;
        rd_q[s1_idx]      <= sb.inst1_rd_i;
      end
      if (wb0_hit) done_q[wb0_idx] <= 1'b1;
      if (wb1_hit) done_q[wb1_idx] <= 1'b1;
      if (ret0) busy_q[h0_idx] <= 1'b0;
      if (ret1) busy_q[h1_idx] <= 1'b0;
      head_q <= head_q + sid_t'(ret0) + sid_t'(ret1);
      tail_q <= tail_q + sid_t'(disp0) + sid_t'(disp1);
    end
  end

  assign sb.stall_inst0_o = stall0;
  assign sb.stall_inst1_o = stall1;
  assign sb.inst0_sid_o   = tail_q;
  assign sb.inst1_sid_o   = sid1;
  assign sb.count_o       = count;
  assign sb.empty_o       = (count == '0);
endmodule
